// File: rtl/updown_counter_param.sv
// -----------------------------------------------------------------------------
// updown_counter_param
//
// Parametrised up/down counter with an enable prescaler, synchronous clear and
// clamped synchronous load. In wrap mode the count rolls over at the bounds.
// In saturate mode it holds at the bounds. The block emits registered
// one-cycle pulses for every step (tick) and for every bound crossing (wrap).
//
// Parameters:
//   WIDTH      counter width in bits (>= 1)
//   MAX_COUNT  highest count value (1 .. 2**WIDTH-1)
//   SATURATE   0 = wrap at the bounds, 1 = hold at the bounds
//   PRESCALE   enabled cycles per count step (>= 1)
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous reset, active-low
//   clear       synchronous clear to 0, active-high (beats load)
//   load        synchronous load of min(load_value, MAX_COUNT), active-high
//   load_value  value to load
//   enable      counting enable, feeds the prescaler
//   count_dir   1 = count up, 0 = count down
//   count       current count (register)
//   tick        registered pulse, one cycle after each step
//   wrap        registered pulse, one cycle after a bound crossing
//   at_max      count == MAX_COUNT
//   at_min      count == 0
// -----------------------------------------------------------------------------
module updown_counter_param #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 2**WIDTH - 1,
    parameter bit SATURATE  = 1'b0,
    parameter int PRESCALE  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             count_dir,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             wrap,
    output logic             at_max,
    output logic             at_min
);

    // The prescaler needs at least one bit, even when PRESCALE = 1.
    localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MAX_COUNT);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_cnt;
    logic [PRE_W-1:0] pre_cnt_next;
    logic [WIDTH-1:0] count_next;
    logic             tick_next;
    logic             wrap_next;
    logic             step;

    // Step strobe: only when neither clear nor load is active, so that a
    // simultaneous clear/load discards the step and its pulses.
    always_comb begin
        // NOTE: every variable gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        step         = 1'b0;
        pre_cnt_next = pre_cnt;
        if (clear || load) begin
            pre_cnt_next = '0;
        end else if (enable) begin
            if (pre_cnt == PRE_LAST) begin
                step         = 1'b1;
                pre_cnt_next = '0;
            end else begin
                pre_cnt_next = pre_cnt + 1'b1;
            end
        end
    end

    // Count update. count never exceeds MAX_VAL (load clamps), so count + 1
    // below MAX_VAL cannot overflow WIDTH bits.
    always_comb begin
        count_next = count;
        tick_next  = 1'b0;
        wrap_next  = 1'b0;
        if (clear) begin
            count_next = '0;
        end else if (load) begin
            count_next = (load_value > MAX_VAL) ? MAX_VAL : load_value;
        end else if (step) begin
            tick_next = 1'b1;
            if (count_dir) begin
                if (count != MAX_VAL) begin
                    count_next = count + 1'b1;
                end else if (!SATURATE) begin
                    count_next = '0;
                    wrap_next  = 1'b1;
                end
            end else begin
                if (count != '0) begin
                    count_next = count - 1'b1;
                end else if (!SATURATE) begin
                    count_next = MAX_VAL;
                    wrap_next  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            pre_cnt <= '0;
            tick    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            count   <= count_next;
            pre_cnt <= pre_cnt_next;
            tick    <= tick_next;
            wrap    <= wrap_next;
        end
    end

    assign at_max = (count == MAX_VAL);
    assign at_min = (count == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
// -----------------------------------------------------------------------------
// tb_updown_counter_param
//
// Four counter instances share one set of inputs:
//   d0: defaults (WIDTH 4, MAX 15, wrap, PRESCALE 1)
//   d1: MAX_COUNT 9, wrap
//   d2: MAX_COUNT 9, saturate
//   d3: MAX_COUNT 9, wrap, PRESCALE 3
// Each directed step pushes the expected outputs of one instance onto a queue.
// The queue is popped and compared once the DUT has produced that output.
// -----------------------------------------------------------------------------
module tb_updown_counter_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       load;
    logic [3:0] load_value;
    logic       enable;
    logic       count_dir;

    logic [3:0] cnt_a [4];
    logic       tk_a  [4];
    logic       wr_a  [4];
    logic       mx_a  [4];
    logic       mn_a  [4];

    always #5 clk = ~clk;

    updown_counter_param d0 (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
        .enable(enable), .count_dir(count_dir), .count(cnt_a[0]), .tick(tk_a[0]),
        .wrap(wr_a[0]), .at_max(mx_a[0]), .at_min(mn_a[0]));

    updown_counter_param #(.MAX_COUNT(9)) d1 (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
        .enable(enable), .count_dir(count_dir), .count(cnt_a[1]), .tick(tk_a[1]),
        .wrap(wr_a[1]), .at_max(mx_a[1]), .at_min(mn_a[1]));

    updown_counter_param #(.MAX_COUNT(9), .SATURATE(1'b1)) d2 (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
        .enable(enable), .count_dir(count_dir), .count(cnt_a[2]), .tick(tk_a[2]),
        .wrap(wr_a[2]), .at_max(mx_a[2]), .at_min(mn_a[2]));

    updown_counter_param #(.MAX_COUNT(9), .PRESCALE(3)) d3 (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
        .enable(enable), .count_dir(count_dir), .count(cnt_a[3]), .tick(tk_a[3]),
        .wrap(wr_a[3]), .at_max(mx_a[3]), .at_min(mn_a[3]));

    typedef struct {
        int         dut;
        logic [3:0] count;
        logic       tick;
        logic       wrap;
        logic       at_max;
        logic       at_min;
    } exp_t;

    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    string phase  = "reset";

    function automatic exp_t mk(int d, int c, bit t, bit w, int mx);
        exp_t e;
        e.dut    = d;
        e.count  = 4'(c);
        e.tick   = t;
        e.wrap   = w;
        e.at_max = (c == mx);
        e.at_min = (c == 0);
        return e;
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s/%s: observed=%0d expected=%0d", phase, tag, obs, expv);
        end
    endtask

    task automatic compare_pop();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s/queue: observed=empty expected=entry", phase);
            return;
        end
        e = exp_q.pop_front();
        chk($sformatf("d%0d.count", e.dut),  8'(cnt_a[e.dut]), 8'(e.count));
        chk($sformatf("d%0d.tick", e.dut),   8'(tk_a[e.dut]),  8'(e.tick));
        chk($sformatf("d%0d.wrap", e.dut),   8'(wr_a[e.dut]),  8'(e.wrap));
        chk($sformatf("d%0d.at_max", e.dut), 8'(mx_a[e.dut]),  8'(e.at_max));
        chk($sformatf("d%0d.at_min", e.dut), 8'(mn_a[e.dut]),  8'(e.at_min));
    endtask

    // Expect e after the next rising edge; sample 1 time unit past the edge.
    task automatic cycle(exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        compare_pop();
    endtask

    // Expect e right now, without waiting for an edge.
    task automatic now(exp_t e);
        exp_q.push_back(e);
        compare_pop();
    endtask

    // Watchdog: the directed sequence is short; never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        clear      = 1'b0;
        load       = 1'b0;
        load_value = 4'd0;
        enable     = 1'b0;
        count_dir  = 1'b1;

        // Reset state on every instance.
        #2;
        for (int k = 0; k < 4; k++) now(mk(k, 0, 0, 0, (k == 0) ? 15 : 9));

        // Release reset mid-cycle, then count up on the default instance.
        @(posedge clk);
        #1;
        reset  = 1'b1;
        enable = 1'b1;
        phase  = "up16";
        for (int i = 1; i <= 17; i++) cycle(mk(0, i % 16, 1, i == 16, 15));

        // Wrap-mode down count, MAX 9.
        phase = "clear1";
        clear = 1'b1;
        cycle(mk(1, 0, 0, 0, 9));
        clear     = 1'b0;
        count_dir = 1'b0;
        phase     = "down9";
        for (int i = 1; i <= 11; i++) begin
            int c;
            c = (10 - (i % 10)) % 10;
            cycle(mk(1, c, 1, c == 9, 9));
        end

        // Saturate mode, load 8 then count up into the bound.
        phase      = "sat_load";
        enable     = 1'b0;
        load       = 1'b1;
        load_value = 4'd8;
        cycle(mk(2, 8, 0, 0, 9));
        load      = 1'b0;
        enable    = 1'b1;
        count_dir = 1'b1;
        phase     = "sat_up";
        for (int i = 0; i < 3; i++) cycle(mk(2, 9, 1, 0, 9));

        // Prescaler: enable pattern 1,1,0,1,1,1,1.
        phase = "pre_clear";
        clear = 1'b1;
        cycle(mk(3, 0, 0, 0, 9));
        clear = 1'b0;
        phase = "prescale";
        begin
            bit en_pat [7]  = '{1, 1, 0, 1, 1, 1, 1};
            int cnt_exp [7] = '{0, 0, 0, 1, 1, 1, 2};
            bit tk_exp [7]  = '{0, 0, 0, 1, 0, 0, 1};
            for (int i = 0; i < 7; i++) begin
                enable = en_pat[i];
                cycle(mk(3, cnt_exp[i], tk_exp[i], 0, 9));
            end
        end

        // Clamped load coinciding with a step condition.
        phase  = "load_clamp";
        enable = 1'b1;
        cycle(mk(3, 2, 0, 0, 9));
        cycle(mk(3, 2, 0, 0, 9));
        load       = 1'b1;
        load_value = 4'd13;
        cycle(mk(3, 9, 0, 0, 9));
        load  = 1'b0;
        phase = "after_load";
        cycle(mk(3, 9, 0, 0, 9));
        cycle(mk(3, 9, 0, 0, 9));
        cycle(mk(3, 0, 1, 1, 9));

        // Mid-count clear, then asynchronous reset between edges.
        phase      = "mid_clear";
        enable     = 1'b0;
        load       = 1'b1;
        load_value = 4'd7;
        cycle(mk(3, 7, 0, 0, 9));
        load   = 1'b0;
        enable = 1'b1;
        cycle(mk(3, 7, 0, 0, 9));
        clear = 1'b1;
        cycle(mk(3, 0, 0, 0, 9));
        clear = 1'b0;
        phase = "mid_reset";
        load  = 1'b1;
        cycle(mk(3, 7, 0, 0, 9));
        load = 1'b0;
        cycle(mk(3, 7, 0, 0, 9));
        cycle(mk(3, 7, 0, 0, 9));
        cycle(mk(3, 8, 1, 0, 9));
        reset = 1'b0;
        #1;
        now(mk(3, 0, 0, 0, 9));
        now(mk(0, 0, 0, 0, 15));
        #1;
        reset = 1'b1;
        phase = "post_reset";
        cycle(mk(3, 0, 0, 0, 9));
        cycle(mk(3, 0, 0, 0, 9));
        cycle(mk(3, 1, 1, 0, 9));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
